// File: rtl/wb_ppfifo_2_mem.sv
// wb_ppfifo_2_mem: Wishbone write master that drains a ping-pong FIFO read port into one of
// two host-configured memory banks, one 32-bit word per Wishbone write cycle. Banks fill
// alternately (lowest-index non-full bank first); o_write_finished pulses when a bank fills.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_enable                      core enable
//   i_memory_N_base/_size         bank N base word address / capacity in words
//   i_memory_N_new_data           pulse: clear bank N pointer (re-arm the bank)
//   o_memory_N_count/_full        bank N pointer / pointer >= size
//   o_write_finished              one-cycle pulse when a bank becomes full
//   o_finished_bank               bank index of the last finished pulse
//   o_mem_*/i_mem_*               Wishbone master (write-only; i_mem_dat, i_mem_int ignored)
//   i_ppfifo_*/o_ppfifo_*         ping-pong FIFO read port (rdy/act/size/stb/data)
module wb_ppfifo_2_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_new_data,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_new_data,
  output logic [31:0] o_memory_0_count,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_0_full,
  output logic        o_memory_1_full,
  output logic        o_write_finished,
  output logic        o_finished_bank,
  output logic        o_mem_we,
  output logic        o_mem_cyc,
  output logic        o_mem_stb,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  input  logic        i_mem_int,
  input  logic        i_ppfifo_rdy,
  output logic        o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  input  logic [31:0] i_ppfifo_data
);

  typedef enum logic [2:0] {
    StIdle,
    StGetBank,
    StWriteSetup,
    StWaitAck,
    StPop,
    StFinished
  } state_e;

  state_e      state_q, state_d;
  logic        bank_q, bank_d;
  logic [31:0] ptr0_q, ptr0_d;
  logic [31:0] ptr1_q, ptr1_d;
  logic [23:0] fifo_count_q, fifo_count_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        act_q, act_d;
  logic        pop_q, pop_d;
  logic        fin_q, fin_d;
  logic        fin_bank_q, fin_bank_d;

  logic        full0, full1;
  logic        active_full;
  logic [31:0] active_base, active_ptr;

  // Read data and interrupt are not used by a write-only master.
  logic unused_inputs;
  assign unused_inputs = ^{i_mem_dat, i_mem_int};

  assign full0       = (ptr0_q >= i_memory_0_size);
  assign full1       = (ptr1_q >= i_memory_1_size);
  assign active_full = bank_q ? full1 : full0;
  assign active_base = bank_q ? i_memory_1_base : i_memory_0_base;
  assign active_ptr  = bank_q ? ptr1_q : ptr0_q;

  assign o_memory_0_count = ptr0_q;
  assign o_memory_1_count = ptr1_q;
  assign o_memory_0_full  = full0;
  assign o_memory_1_full  = full1;
  assign o_write_finished = fin_q;
  assign o_finished_bank  = fin_bank_q;
  assign o_mem_we         = cyc_q;
  assign o_mem_cyc        = cyc_q;
  assign o_mem_stb        = stb_q;
  assign o_mem_sel        = 4'b1111;
  assign o_mem_adr        = adr_q;
  assign o_mem_dat        = dat_q;
  assign o_ppfifo_act     = act_q;
  assign o_ppfifo_stb     = pop_q;

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    ptr0_d       = ptr0_q;
    ptr1_d       = ptr1_q;
    fifo_count_d = fifo_count_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    act_d        = act_q;
    pop_d        = 1'b0;
    fin_d        = 1'b0;
    fin_bank_d   = fin_bank_q;

    unique case (state_q)
      StIdle: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (i_enable) state_d = StGetBank;
      end
      StGetBank: begin
        if (!i_enable) begin
          state_d = StIdle;
        end else if (!full0) begin
          bank_d  = 1'b0;
          state_d = StWriteSetup;
        end else if (!full1) begin
          bank_d  = 1'b1;
          state_d = StWriteSetup;
        end
      end
      StWriteSetup: begin
        if (active_full) begin
          cyc_d   = 1'b0;
          state_d = StFinished;
        end else if (!i_enable) begin
          // The FIFO buffer stays held so re-enabling resumes mid-buffer.
          cyc_d   = 1'b0;
          state_d = StIdle;
        end else if (!act_q) begin
          cyc_d = 1'b0;
          if (i_ppfifo_rdy) begin
            act_d        = 1'b1;
            fifo_count_d = '0;
          end
        end else if (fifo_count_q >= i_ppfifo_size) begin
          act_d = 1'b0;
          cyc_d = 1'b0;
        end else begin
          dat_d   = i_ppfifo_data;
          adr_d   = active_base + active_ptr;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (i_mem_ack && stb_q) begin
          stb_d        = 1'b0;
          pop_d        = 1'b1;
          fifo_count_d = fifo_count_q + 24'd1;
          if (bank_q) ptr1_d = ptr1_q + 32'd1;
          else        ptr0_d = ptr0_q + 32'd1;
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StWriteSetup;
      end
      StFinished: begin
        fin_d      = 1'b1;
        fin_bank_d = bank_q;
        state_d    = StGetBank;
      end
      default: state_d = StIdle;
    endcase

    // Host re-arm wins over a same-cycle increment.
    if (i_memory_0_new_data) ptr0_d = '0;
    if (i_memory_1_new_data) ptr1_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bank_q       <= 1'b0;
      ptr0_q       <= '0;
      ptr1_q       <= '0;
      fifo_count_q <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      act_q        <= 1'b0;
      pop_q        <= 1'b0;
      fin_q        <= 1'b0;
      fin_bank_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      ptr0_q       <= ptr0_d;
      ptr1_q       <= ptr1_d;
      fifo_count_q <= fifo_count_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      act_q        <= act_d;
      pop_q        <= pop_d;
      fin_q        <= fin_d;
      fin_bank_q   <= fin_bank_d;
    end
  end

endmodule

// File: tb/tb_wb_ppfifo_2_mem.sv
// Self-checking bench for wb_ppfifo_2_mem: a FIFO producer model and a Wishbone slave model
// run on the falling edge; each test compares the logged writes and final state against
// values computed from the bank/stream rules.
module tb_wb_ppfifo_2_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [31:0] i_memory_0_base, i_memory_0_size, i_memory_1_base, i_memory_1_size;
  logic        i_memory_0_new_data, i_memory_1_new_data;
  logic [31:0] o_memory_0_count, o_memory_1_count;
  logic        o_memory_0_full, o_memory_1_full;
  logic        o_write_finished, o_finished_bank;
  logic        o_mem_we, o_mem_cyc, o_mem_stb;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [31:0] i_mem_dat;
  logic        i_mem_ack, i_mem_int;
  logic        i_ppfifo_rdy, o_ppfifo_act, o_ppfifo_stb;
  logic [23:0] i_ppfifo_size;
  logic [31:0] i_ppfifo_data;

  always #5 clk = ~clk;

  wb_ppfifo_2_mem dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_enable            (i_enable),
    .i_memory_0_base     (i_memory_0_base),
    .i_memory_0_size     (i_memory_0_size),
    .i_memory_0_new_data (i_memory_0_new_data),
    .i_memory_1_base     (i_memory_1_base),
    .i_memory_1_size     (i_memory_1_size),
    .i_memory_1_new_data (i_memory_1_new_data),
    .o_memory_0_count    (o_memory_0_count),
    .o_memory_1_count    (o_memory_1_count),
    .o_memory_0_full     (o_memory_0_full),
    .o_memory_1_full     (o_memory_1_full),
    .o_write_finished    (o_write_finished),
    .o_finished_bank     (o_finished_bank),
    .o_mem_we            (o_mem_we),
    .o_mem_cyc           (o_mem_cyc),
    .o_mem_stb           (o_mem_stb),
    .o_mem_sel           (o_mem_sel),
    .o_mem_adr           (o_mem_adr),
    .o_mem_dat           (o_mem_dat),
    .i_mem_dat           (i_mem_dat),
    .i_mem_ack           (i_mem_ack),
    .i_mem_int           (i_mem_int),
    .i_ppfifo_rdy        (i_ppfifo_rdy),
    .o_ppfifo_act        (o_ppfifo_act),
    .i_ppfifo_size       (i_ppfifo_size),
    .o_ppfifo_stb        (o_ppfifo_stb),
    .i_ppfifo_data       (i_ppfifo_data)
  );

  int total = 0;
  int bad = 0;

  // Producer model: flat word queue, one size entry per pending buffer (front = held/next).
  logic [31:0] fifo_words[$];
  int          buf_sizes[$];
  int          idx = 0;
  logic        prev_act = 1'b0;
  int          act_rises = 0;

  // Slave model and logs.
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          nd_trigger = -1;
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  int          fin_bank[$];

  always @(negedge clk) begin
    if (o_ppfifo_stb) idx++;
    if (!prev_act && o_ppfifo_act) act_rises++;
    if (prev_act && !o_ppfifo_act && buf_sizes.size() > 0) begin
      for (int k = 0; k < buf_sizes[0]; k++) void'(fifo_words.pop_front());
      void'(buf_sizes.pop_front());
      idx = 0;
    end
    prev_act = o_ppfifo_act;
    i_ppfifo_rdy  = (buf_sizes.size() > 0);
    i_ppfifo_size = (buf_sizes.size() > 0) ? 24'(buf_sizes[0]) : 24'd0;
    i_ppfifo_data = (buf_sizes.size() > 0 && idx < buf_sizes[0]) ? fifo_words[idx]
                                                                 : 32'hDEAD_BEEF;

    i_memory_0_new_data = 1'b0;
    if (o_mem_cyc && o_mem_stb && !i_mem_ack) begin
      if (wait_cnt >= ack_delay) begin
        i_mem_ack = 1'b1;
        if (wr_adr.size() == nd_trigger) i_memory_0_new_data = 1'b1;
        wr_adr.push_back(o_mem_adr);
        wr_dat.push_back(o_mem_dat);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
      wait_cnt  = 0;
    end
    if (o_write_finished) fin_bank.push_back(int'(o_finished_bank));
  end

  task automatic do_reset();
    i_enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    fifo_words.delete();
    buf_sizes.delete();
    wr_adr.delete();
    wr_dat.delete();
    fin_bank.delete();
    idx = 0;
    prev_act = 1'b0;
    act_rises = 0;
    ack_delay = 0;
    nd_trigger = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_buf(input int n, input logic [31:0] first);
    for (int k = 0; k < n; k++) fifo_words.push_back(first + 32'(k));
    buf_sizes.push_back(n);
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    for (int c = 0; c < budget && wr_adr.size() < n; c++) @(negedge clk);
    total++;
    if (wr_adr.size() < n) begin
      bad++;
      $display("FAIL %s timeout: writes=%0d required=%0d", name, wr_adr.size(), n);
    end
  endtask

  task automatic test_reset();
    i_memory_0_base = 32'h10; i_memory_0_size = 4;
    i_memory_1_base = 32'h20; i_memory_1_size = 4;
    do_reset();
    @(negedge clk);
    total += 10;
    if (o_mem_cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got %b want 0", o_mem_cyc); end
    if (o_mem_stb !== 1'b0) begin bad++; $display("FAIL rst_stb got %b want 0", o_mem_stb); end
    if (o_mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got %b want 0", o_mem_we); end
    if (o_mem_sel !== 4'b1111) begin bad++; $display("FAIL rst_sel got %b want 1111", o_mem_sel); end
    if (o_mem_adr !== 32'd0) begin bad++; $display("FAIL rst_adr got %h want 0", o_mem_adr); end
    if (o_memory_0_count !== 32'd0) begin bad++; $display("FAIL rst_cnt0 got %0d want 0", o_memory_0_count); end
    if (o_memory_1_count !== 32'd0) begin bad++; $display("FAIL rst_cnt1 got %0d want 0", o_memory_1_count); end
    if (o_memory_0_full !== 1'b0) begin bad++; $display("FAIL rst_full0 got %b want 0", o_memory_0_full); end
    if (o_ppfifo_act !== 1'b0) begin bad++; $display("FAIL rst_act got %b want 0", o_ppfifo_act); end
    if (o_write_finished !== 1'b0) begin bad++; $display("FAIL rst_fin got %b want 0", o_write_finished); end
  endtask

  task automatic test_basic_fill();
    i_memory_0_base = 32'h100; i_memory_0_size = 4;
    i_memory_1_base = 32'h0;   i_memory_1_size = 0;
    do_reset();
    push_buf(4, 32'hA0);
    i_enable = 1'b1;
    wait_writes(4, 200, "basic");
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4 && k < wr_adr.size(); k++) begin
      total += 2;
      if (wr_adr[k] !== 32'h100 + 32'(k)) begin
        bad++; $display("FAIL basic_adr[%0d] got %h want %h", k, wr_adr[k], 32'h100 + 32'(k));
      end
      if (wr_dat[k] !== 32'hA0 + 32'(k)) begin
        bad++; $display("FAIL basic_dat[%0d] got %h want %h", k, wr_dat[k], 32'hA0 + 32'(k));
      end
    end
    total += 4;
    if (o_memory_0_count !== 32'd4) begin bad++; $display("FAIL basic_cnt0 got %0d want 4", o_memory_0_count); end
    if (o_memory_0_full !== 1'b1) begin bad++; $display("FAIL basic_full0 got %b want 1", o_memory_0_full); end
    if (fin_bank.size() !== 1) begin bad++; $display("FAIL basic_fin_count got %0d want 1", fin_bank.size()); end
    else if (fin_bank[0] !== 0) begin bad++; $display("FAIL basic_fin_bank got %0d want 0", fin_bank[0]); end
    if (wr_adr.size() !== 4) begin bad++; $display("FAIL basic_nwrites got %0d want 4", wr_adr.size()); end
  endtask

  task automatic test_rollover();
    i_memory_0_base = 32'h200;   i_memory_0_size = 2;
    i_memory_1_base = 32'h80000; i_memory_1_size = 3;
    do_reset();
    push_buf(5, 32'hB0);
    i_enable = 1'b1;
    wait_writes(5, 300, "roll");
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5 && k < wr_adr.size(); k++) begin
      logic [31:0] ea;
      ea = (k < 2) ? 32'h200 + 32'(k) : 32'h80000 + 32'(k - 2);
      total += 2;
      if (wr_adr[k] !== ea) begin bad++; $display("FAIL roll_adr[%0d] got %h want %h", k, wr_adr[k], ea); end
      if (wr_dat[k] !== 32'hB0 + 32'(k)) begin
        bad++; $display("FAIL roll_dat[%0d] got %h want %h", k, wr_dat[k], 32'hB0 + 32'(k));
      end
    end
    total += 3;
    if (fin_bank.size() !== 2) begin bad++; $display("FAIL roll_fin_count got %0d want 2", fin_bank.size()); end
    else if (fin_bank[0] !== 0 || fin_bank[1] !== 1) begin
      bad++; $display("FAIL roll_fin_banks got %0d,%0d want 0,1", fin_bank[0], fin_bank[1]);
    end
    if (act_rises !== 1) begin bad++; $display("FAIL roll_act_periods got %0d want 1", act_rises); end
    if (o_memory_1_count !== 32'd3) begin bad++; $display("FAIL roll_cnt1 got %0d want 3", o_memory_1_count); end
  endtask

  task automatic test_exhaust();
    i_memory_0_base = 32'h300; i_memory_0_size = 6;
    i_memory_1_base = 32'h0;   i_memory_1_size = 0;
    do_reset();
    push_buf(3, 32'hC0);
    i_enable = 1'b1;
    wait_writes(3, 200, "exh_first");
    repeat (10) @(negedge clk);
    total += 3;
    if (o_ppfifo_act !== 1'b0) begin bad++; $display("FAIL exh_act_released got %b want 0", o_ppfifo_act); end
    if (o_mem_cyc !== 1'b0) begin bad++; $display("FAIL exh_cyc_idle got %b want 0", o_mem_cyc); end
    if (fin_bank.size() !== 0) begin bad++; $display("FAIL exh_early_fin got %0d want 0", fin_bank.size()); end
    push_buf(3, 32'hC3);
    wait_writes(6, 200, "exh_second");
    repeat (10) @(negedge clk);
    for (int k = 0; k < 6 && k < wr_adr.size(); k++) begin
      total += 2;
      if (wr_adr[k] !== 32'h300 + 32'(k)) begin
        bad++; $display("FAIL exh_adr[%0d] got %h want %h", k, wr_adr[k], 32'h300 + 32'(k));
      end
      if (wr_dat[k] !== 32'hC0 + 32'(k)) begin
        bad++; $display("FAIL exh_dat[%0d] got %h want %h", k, wr_dat[k], 32'hC0 + 32'(k));
      end
    end
    total += 2;
    if (fin_bank.size() !== 1) begin bad++; $display("FAIL exh_fin_count got %0d want 1", fin_bank.size()); end
    if (act_rises !== 2) begin bad++; $display("FAIL exh_act_periods got %0d want 2", act_rises); end
  endtask

  task automatic test_wait_enable();
    i_memory_0_base = 32'h500; i_memory_0_size = 4;
    i_memory_1_base = 32'h0;   i_memory_1_size = 0;
    do_reset();
    push_buf(4, 32'hD0);
    ack_delay = 5;
    i_enable = 1'b1;
    for (int c = 0; c < 50 && !o_mem_stb; c++) @(negedge clk);
    i_enable = 1'b0;
    wait_writes(1, 50, "wen_first");
    repeat (12) @(negedge clk);
    total += 4;
    if (o_memory_0_count !== 32'd1) begin bad++; $display("FAIL wen_cnt0 got %0d want 1", o_memory_0_count); end
    if (o_mem_cyc !== 1'b0) begin bad++; $display("FAIL wen_cyc got %b want 0", o_mem_cyc); end
    if (o_ppfifo_act !== 1'b1) begin bad++; $display("FAIL wen_act_held got %b want 1", o_ppfifo_act); end
    if (wr_adr.size() !== 1) begin bad++; $display("FAIL wen_nwrites got %0d want 1", wr_adr.size()); end
    ack_delay = 0;
    i_enable = 1'b1;
    wait_writes(4, 200, "wen_resume");
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4 && k < wr_adr.size(); k++) begin
      total += 2;
      if (wr_adr[k] !== 32'h500 + 32'(k)) begin
        bad++; $display("FAIL wen_adr[%0d] got %h want %h", k, wr_adr[k], 32'h500 + 32'(k));
      end
      if (wr_dat[k] !== 32'hD0 + 32'(k)) begin
        bad++; $display("FAIL wen_dat[%0d] got %h want %h", k, wr_dat[k], 32'hD0 + 32'(k));
      end
    end
  endtask

  task automatic test_new_data();
    i_memory_0_base = 32'h40; i_memory_0_size = 4;
    i_memory_1_base = 32'h0;  i_memory_1_size = 0;
    do_reset();
    push_buf(6, 32'hE0);
    nd_trigger = 2;  // re-arm coincides with the ack of the third word (ptr0 = 2)
    i_enable = 1'b1;
    wait_writes(3, 200, "nd_third");
    @(negedge clk);
    total += 2;
    if (o_memory_0_count !== 32'd0) begin bad++; $display("FAIL nd_cnt0 got %0d want 0", o_memory_0_count); end
    if (o_memory_0_full !== 1'b0) begin bad++; $display("FAIL nd_full0 got %b want 0", o_memory_0_full); end
    wait_writes(6, 200, "nd_all");
    repeat (10) @(negedge clk);
    for (int k = 0; k < 6 && k < wr_adr.size(); k++) begin
      logic [31:0] ea;
      ea = 32'h40 + 32'(k % 3);
      total += 2;
      if (wr_adr[k] !== ea) begin bad++; $display("FAIL nd_adr[%0d] got %h want %h", k, wr_adr[k], ea); end
      if (wr_dat[k] !== 32'hE0 + 32'(k)) begin
        bad++; $display("FAIL nd_dat[%0d] got %h want %h", k, wr_dat[k], 32'hE0 + 32'(k));
      end
    end
    total += 2;
    if (o_memory_0_count !== 32'd3) begin bad++; $display("FAIL nd_cnt0_end got %0d want 3", o_memory_0_count); end
    if (fin_bank.size() !== 0) begin bad++; $display("FAIL nd_fin got %0d want 0", fin_bank.size()); end
  endtask

  task automatic test_reset_mid();
    i_memory_0_base = 32'h700; i_memory_0_size = 4;
    i_memory_1_base = 32'h0;   i_memory_1_size = 0;
    do_reset();
    push_buf(4, 32'hF0);
    i_enable = 1'b1;
    wait_writes(2, 200, "rmid_pre");
    ack_delay = 50;
    for (int c = 0; c < 50 && !(o_mem_stb && !i_mem_ack); c++) @(negedge clk);
    total++;
    if (o_mem_stb !== 1'b1) begin bad++; $display("FAIL rmid_stb_pre got %b want 1", o_mem_stb); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total += 6;
    if (o_mem_cyc !== 1'b0) begin bad++; $display("FAIL rmid_cyc got %b want 0", o_mem_cyc); end
    if (o_mem_stb !== 1'b0) begin bad++; $display("FAIL rmid_stb got %b want 0", o_mem_stb); end
    if (o_ppfifo_act !== 1'b0) begin bad++; $display("FAIL rmid_act got %b want 0", o_ppfifo_act); end
    if (o_memory_0_count !== 32'd0) begin bad++; $display("FAIL rmid_cnt0 got %0d want 0", o_memory_0_count); end
    if (o_memory_1_count !== 32'd0) begin bad++; $display("FAIL rmid_cnt1 got %0d want 0", o_memory_1_count); end
    if (o_mem_sel !== 4'b1111) begin bad++; $display("FAIL rmid_sel got %b want 1111", o_mem_sel); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int s0, s1, nbuf, n, cap, nw, e0, e1;
      logic [31:0] stream[$];
      int exp_fin[$];
      s0 = $urandom_range(1, 6);
      s1 = $urandom_range(1, 6);
      i_memory_0_base = (it == 0) ? 32'hFFFF_FFFE : $urandom;
      i_memory_1_base = $urandom;
      i_memory_0_size = 32'(s0);
      i_memory_1_size = 32'(s1);
      do_reset();
      ack_delay = $urandom_range(0, 3);
      nbuf = $urandom_range(1, 3);
      for (int b = 0; b < nbuf; b++) begin
        int bs;
        bs = $urandom_range(0, 5);
        for (int k = 0; k < bs; k++) begin
          logic [31:0] w;
          w = $urandom;
          fifo_words.push_back(w);
          stream.push_back(w);
        end
        buf_sizes.push_back(bs);
      end
      n = stream.size();
      cap = s0 + s1;
      nw = (n < cap) ? n : cap;
      e0 = (n < s0) ? n : s0;
      e1 = (n - s0 < 0) ? 0 : ((n - s0 < s1) ? n - s0 : s1);
      if (n >= s0) exp_fin.push_back(0);
      if (n >= cap) exp_fin.push_back(1);
      i_enable = 1'b1;
      wait_writes(nw, 400, "rnd");
      repeat (30) @(negedge clk);
      total++;
      if (wr_adr.size() !== nw) begin
        bad++; $display("FAIL rnd%0d_nwrites got %0d want %0d", it, wr_adr.size(), nw);
      end
      for (int k = 0; k < nw && k < wr_adr.size(); k++) begin
        logic [31:0] ea;
        ea = (k < s0) ? i_memory_0_base + 32'(k) : i_memory_1_base + 32'(k - s0);
        total += 2;
        if (wr_adr[k] !== ea) begin
          bad++; $display("FAIL rnd%0d_adr[%0d] got %h want %h", it, k, wr_adr[k], ea);
        end
        if (wr_dat[k] !== stream[k]) begin
          bad++; $display("FAIL rnd%0d_dat[%0d] got %h want %h", it, k, wr_dat[k], stream[k]);
        end
      end
      total += 3;
      if (o_memory_0_count !== 32'(e0)) begin
        bad++; $display("FAIL rnd%0d_cnt0 got %0d want %0d", it, o_memory_0_count, e0);
      end
      if (o_memory_1_count !== 32'(e1)) begin
        bad++; $display("FAIL rnd%0d_cnt1 got %0d want %0d", it, o_memory_1_count, e1);
      end
      if (fin_bank != exp_fin) begin
        bad++; $display("FAIL rnd%0d_fin got %0d pulses want %0d", it, fin_bank.size(), exp_fin.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_enable = 1'b0;
    i_memory_0_base = '0; i_memory_0_size = '0;
    i_memory_1_base = '0; i_memory_1_size = '0;
    i_memory_0_new_data = 1'b0;
    i_memory_1_new_data = 1'b0;
    i_mem_dat = '0;
    i_mem_ack = 1'b0;
    i_mem_int = 1'b0;
    i_ppfifo_rdy = 1'b0;
    i_ppfifo_size = '0;
    i_ppfifo_data = '0;
    test_reset();
    test_basic_fill();
    test_rollover();
    test_exhaust();
    test_wait_enable();
    test_new_data();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
